cntr_frame_seq: RTL and testbench

Parametrised successor to the single-terminal-count TX frame bit counter. Sequences one serial TX frame (start bit, a runtime-selectable number of data bits, optional parity bit, one or two stop bits) under a baud-tick enable. Reports the current field and bit index to the TX shift/mux logic, and pulses an overflow at end of frame. Sits between the baud generator and the TX datapath in the UART transmitter.

---
 rtl/cntr_frame_seq_if.sv | 31 +++
 rtl/cntr_frame_seq.sv | 148 ++++++++++++++
 tb/tb_cntr_frame_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cntr_frame_seq_if.sv
// cntr_frame_seq_if: control/status bundle between the baud/TX control side
// and the frame bit sequencer.
//   master: drives enb, clear, start, data_len, two_stop;
//           observes busy, field, bit_idx, ovf, frame_cnt.
//   slave : the sequencer side (mirror of master).
// IDX_W sizes data_len/bit_idx; FRM_W sizes frame_cnt.
interface cntr_frame_seq_if #(
  parameter int IDX_W = 4,
  parameter int FRM_W = 8
);
  logic             enb;
  logic             clear;
  logic             start;
  logic [IDX_W-1:0] data_len;
  logic             two_stop;
  logic             busy;
  logic [2:0]       field;
  logic [IDX_W-1:0] bit_idx;
  logic             ovf;
  logic [FRM_W-1:0] frame_cnt;

  modport master (
    output enb, clear, start, data_len, two_stop,
    input  busy, field, bit_idx, ovf, frame_cnt
  );

  modport slave (
    input  enb, clear, start, data_len, two_stop,
    output busy, field, bit_idx, ovf, frame_cnt
  );
endinterface

// File: rtl/cntr_frame_seq.sv
// cntr_frame_seq: sequences one serial TX frame (START, 1..MAX_DATA data bits,
// optional PARITY, one or two STOP bits), advancing one bit period per baud
// tick. Reports the current field and bit index to the TX shift/mux logic,
// pulses ovf at end of frame and counts completed frames.
// Ports:
//   clk  - rising-edge system clock
//   rst  - asynchronous active-low reset
//   bus  - cntr_frame_seq_if.slave
//          in : enb (baud tick), clear (sync abort, highest priority),
//               start (frame request, IDLE only), data_len, two_stop
//          out: busy, field (0 IDLE,1 START,2 DATA,3 PARITY,4 STOP),
//               bit_idx, ovf (end-of-frame pulse), frame_cnt (wraps)
// Build option: define CNTR_FRAME_PARITY_EN to insert a PARITY bit period
// between DATA and STOP; without it field never reads 3.
module cntr_frame_seq #(
  parameter int MAX_DATA = 8,
  parameter int IDX_W    = $clog2(MAX_DATA + 1),
  parameter int FRM_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  cntr_frame_seq_if.slave bus
);

  // Encodings double as the field output value.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef CNTR_FRAME_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(MAX_DATA);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             two_stop_q, two_stop_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    len_d       = len_q;
    two_stop_d  = two_stop_q;
    ovf_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (bus.clear) begin
      state_d     = S_IDLE;
      bit_idx_d   = '0;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d    = S_START;
            bit_idx_d  = '0;
            two_stop_d = bus.two_stop;
            // Clamp the requested length into 1..MAX_DATA at latch time.
            if (bus.data_len == '0)          len_d = ONE;
            else if (bus.data_len > MAX_LEN) len_d = MAX_LEN;
            else                             len_d = bus.data_len;
          end
        end
        S_START: begin
          if (bus.enb) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
        S_DATA: begin
          if (bus.enb) begin
            if (bit_idx_q == len_q - ONE) begin
`ifdef CNTR_FRAME_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_idx_q + ONE;
            end
          end
        end
`ifdef CNTR_FRAME_PARITY_EN
        S_PARITY: begin
          if (bus.enb) begin
            state_d   = S_STOP;
            bit_idx_d = '0;
          end
        end
`endif
        S_STOP: begin
          if (bus.enb) begin
            if (two_stop_q && (bit_idx_q == '0)) begin
              bit_idx_d = ONE;
            end else begin
              state_d     = S_IDLE;
              bit_idx_d   = '0;
              ovf_d       = 1'b1;
              frame_cnt_d = frame_cnt_q + FRM_W'(1);
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          bit_idx_d = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bit_idx_q   <= '0;
      len_q       <= ONE;
      two_stop_q  <= 1'b1;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      len_q       <= len_d;
      two_stop_q  <= two_stop_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.field     = state_q;
  assign bus.bit_idx   = bit_idx_q;
  assign bus.ovf       = ovf_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cntr_frame_seq.sv
// tb_cntr_frame_seq: directed bench for cntr_frame_seq. A frame-level model
// expands each accepted request into its list of (field, bit_idx) bit
// periods and consumes one entry per baud tick; outputs are compared against
// it every cycle, and literal tick/field counts pin the model per scenario.
module tb_cntr_frame_seq;
  localparam int MAX_DATA = 8;
  localparam int IDX_W    = $clog2(MAX_DATA + 1);
  localparam int FRM_W    = 8;
`ifdef CNTR_FRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cntr_frame_seq_if #(.IDX_W(IDX_W), .FRM_W(FRM_W)) bus ();

  cntr_frame_seq #(
    .MAX_DATA(MAX_DATA),
    .IDX_W   (IDX_W),
    .FRM_W   (FRM_W)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int q_field[$];
  int q_idx[$];
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  function automatic void build_frame(input int dl, input bit ts);
    int l;
    l = (dl == 0) ? 1 : ((dl > MAX_DATA) ? MAX_DATA : dl);
    q_field.push_back(1); q_idx.push_back(0);
    for (int i = 0; i < l; i++) begin
      q_field.push_back(2); q_idx.push_back(i);
    end
    if (P == 1) begin
      q_field.push_back(3); q_idx.push_back(0);
    end
    q_field.push_back(4); q_idx.push_back(0);
    if (ts) begin
      q_field.push_back(4); q_idx.push_back(1);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_field.delete(); q_idx.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b0;
      if (bus.clear) begin
        q_field.delete(); q_idx.delete();
        m_cnt = 0;
      end else if (q_field.size() == 0) begin
        if (bus.start) build_frame(int'(bus.data_len), bus.two_stop);
      end else if (bus.enb) begin
        void'(q_field.pop_front());
        void'(q_idx.pop_front());
        if (q_field.size() == 0) begin
          m_ovf = 1'b1;
          m_cnt = (m_cnt + 1) % (1 << FRM_W);
        end
      end
    end
  end

  // Per-cycle compare, half a period away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",      bus.busy,      (q_field.size() != 0) ? 1 : 0);
      chk("field",     bus.field,     (q_field.size() != 0) ? q_field[0] : 0);
      chk("bit_idx",   bus.bit_idx,   (q_idx.size() != 0) ? q_idx[0] : 0);
      chk("ovf",       bus.ovf,       m_ovf);
      chk("frame_cnt", bus.frame_cnt, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requests one frame, then ticks enb every `period` cycles until ovf.
  // Counts ticks per field seen before each edge.
  task automatic run_frame(input int len, input bit ts, input int period,
                           input bit hold, input int inject_at,
                           output int ticks, output int dticks,
                           output int pticks, output int sticks);
    bit         done;
    logic [2:0] f;
    done = 1'b0;
    ticks = 0; dticks = 0; pticks = 0; sticks = 0;
    bus.data_len = IDX_W'(len);
    bus.two_stop = ts;
    bus.start    = 1'b1;
    bus.enb      = 1'b0;
    step();
    chk("accept_field", bus.field, 1);
    chk("accept_idx",   bus.bit_idx, 0);
    bus.start = hold;
    for (int c = 0; c < 4000 && !done; c++) begin
      f = bus.field;
      bus.enb   = ((c % period) == (period - 1));
      bus.start = (c == inject_at) ? 1'b1 : hold;
      step();
      if (c == inject_at) chk("ignored_start_busy", bus.busy, 1);
      if (bus.enb && (f != 3'd0)) begin
        ticks++;
        if (f == 3'd2) dticks++;
        if (f == 3'd3) pticks++;
        if (f == 3'd4) sticks++;
      end
      if (bus.ovf) done = 1'b1;
    end
    if (!done) chk("frame_timeout", 0, 1);
    bus.enb = 1'b0;
  endtask

  initial begin
    int t, d, p, s;
    bit reached;
    bus.enb = 1'b0; bus.clear = 1'b0; bus.start = 1'b0;
    bus.data_len = '0; bus.two_stop = 1'b0;

    // Reset values
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_field", bus.field, 0);
    chk("rst_cnt", bus.frame_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Async reset in the middle of DATA at bit_idx 3
    bus.data_len = IDX_W'(8); bus.two_stop = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.enb = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      step();
      if (bus.field == 3'd2 && bus.bit_idx == IDX_W'(3)) reached = 1'b1;
    end
    chk("reach_data3", reached, 1);
    bus.enb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_field", bus.field, 0);
    chk("arst_idx", bus.bit_idx, 0);
    chk("arst_ovf", bus.ovf, 0);
    chk("arst_cnt", bus.frame_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    chk("post_arst_cnt", bus.frame_cnt, 0);

    // 8N1, enb every cycle
    run_frame(8, 1'b0, 1, 1'b0, -1, t, d, p, s);
    chk("8n1_ticks", t, 10 + P);
    chk("8n1_data", d, 8);
    chk("8n1_parity", p, P);
    chk("8n1_stop", s, 1);
    chk("8n1_cnt", bus.frame_cnt, 1);
    step();
    chk("8n1_ovf_one_cycle", bus.ovf, 0);

    // 5 data bits, two stops, enb every 16 cycles
    run_frame(5, 1'b1, 16, 1'b0, -1, t, d, p, s);
    chk("5x2_ticks", t, 8 + P);
    chk("5x2_data", d, 5);
    chk("5x2_parity", p, P);
    chk("5x2_stop", s, 2);
    chk("5x2_cnt", bus.frame_cnt, 2);

    // Length clamps and an ignored mid-frame start
    run_frame(0, 1'b0, 1, 1'b0, -1, t, d, p, s);
    chk("clamp0_data", d, 1);
    run_frame(31, 1'b0, 1, 1'b0, 5, t, d, p, s);
    chk("clampmax_data", d, MAX_DATA);
    chk("clamp_cnt", bus.frame_cnt, 4);

    // Back-to-back with start held high
    for (int i = 0; i < 3; i++) begin
      run_frame(2, 1'b0, 1, 1'b1, -1, t, d, p, s);
      chk("b2b_ticks", t, 4 + P);
    end
    bus.start = 1'b0;
    chk("b2b_cnt", bus.frame_cnt, 7);

    // Clear with start in DATA
    bus.data_len = IDX_W'(4); bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.enb = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      step();
      if (bus.field == 3'd2) reached = 1'b1;
    end
    chk("reach_data_clr", reached, 1);
    bus.clear = 1'b1; bus.start = 1'b1;
    step();
    chk("clr_busy", bus.busy, 0);
    chk("clr_field", bus.field, 0);
    chk("clr_ovf", bus.ovf, 0);
    chk("clr_cnt", bus.frame_cnt, 0);
    bus.clear = 1'b0; bus.start = 1'b0; bus.enb = 1'b0;
    step();
    chk("clr_no_accept", bus.busy, 0);

    // frame_cnt wrap
    for (int i = 0; i < 255; i++) run_frame(0, 1'b0, 1, 1'b1, -1, t, d, p, s);
    chk("cnt_255", bus.frame_cnt, 255);
    run_frame(0, 1'b0, 1, 1'b0, -1, t, d, p, s);
    chk("cnt_wrap", bus.frame_cnt, 0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
